mp_add_seq: RTL

Multi-precision add/subtract sequencer. It streams WORDS×N-bit operands through a single shared N-bit `full_add` instance, one N-bit chunk per clock, least-significant chunk first, and chains the carry through a register. It sits between an upstream operand source and a downstream result consumer, with valid/ready handshakes on both sides. It lets wide arithmetic reuse the small ripple adder instead of instantiating a WORDS×N-bit one.

---
 rtl/mp_add_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS chunks of N bits through
// one shared full_add, LS chunk first, chaining the carry through a register.

module full_add #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_carry,
  output logic [N-1:0] output_sum,
  output logic         output_carry
);

  assign {output_carry, output_sum} = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, in_carry};

endmodule

module mp_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_carry,
  input  logic               op_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_carry,
  output logic               out_overflow
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic          out_carry_q;
  logic          overflow_q;

  logic [N-1:0]  fa_a;
  logic [N-1:0]  fa_b;
  logic [N-1:0]  fa_sum;
  logic          fa_carry;
  logic          last_chunk;

  assign fa_a       = a_q[int'(idx_q)*N +: N];
  assign fa_b       = b_q[int'(idx_q)*N +: N];
  assign last_chunk = (idx_q == IW'(WORDS - 1));

  full_add #(.N(N)) u_full_add (
    .in_a         (fa_a),
    .in_b         (fa_b),
    .in_carry     (carry_q),
    .output_sum   (fa_sum),
    .output_carry (fa_carry)
  );

  // Handshake flags come straight from the state register: no input-to-output path.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_sum      = sum_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = overflow_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make ordering inside the block matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_carry_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + ~borrow, so invert once here and reuse the adder.
            a_q     <= in_a;
            b_q     <= op_sub ? ~in_b : in_b;
            carry_q <= op_sub ? ~in_carry : in_carry;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx_q)*N +: N] <= fa_sum;
          carry_q                   <= fa_carry;
          if (last_chunk) begin
            out_carry_q <= fa_carry;
            overflow_q  <= (a_q[W-1] == b_q[W-1]) && (fa_sum[N-1] != a_q[W-1]);
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
